// File: rtl/map_bilinear_sampler_if.sv
// rtl/map_bilinear_sampler_if.sv - point request, map RAM read port and result bundle for the bilinear sampler
interface map_bilinear_sampler_if;
    // point request
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    // map RAM read port
    logic [11:0] ram_address;
    logic        ram_read_enable;
    logic [7:0]  ram_read_data;
    // interpolated result
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [31:0] out_gradient_x;
    logic [31:0] out_gradient_y;
    logic        out_of_bounds;

    modport slave (
        input  in_valid, in_x, in_y, ram_read_data, out_ready,
        output in_ready, ram_address, ram_read_enable,
        output out_valid, out_value, out_gradient_x, out_gradient_y, out_of_bounds
    );

    modport master (
        output in_valid, in_x, in_y, ram_read_data, out_ready,
        input  in_ready, ram_address, ram_read_enable,
        input  out_valid, out_value, out_gradient_x, out_gradient_y, out_of_bounds
    );
endinterface

// File: rtl/map_bilinear_sampler.sv
// rtl/map_bilinear_sampler.sv - bilinear occupancy/gradient sampler over a 128x32 map RAM
module map_bilinear_sampler (
    input  logic                         clk,
    input  logic                         rst_n,
    map_bilinear_sampler_if.slave        bus
);
    localparam int MAP_WIDTH  = 128;
    localparam int MAP_HEIGHT = 32;
    localparam int WORD_SIZE  = 8;
    localparam int FRAC_BITS  = 18;

    localparam logic signed [13:0] X_MAX = 14'(MAP_WIDTH - 2);
    localparam logic signed [13:0] Y_MAX = 14'(MAP_HEIGHT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CALC,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_in_ready;
    logic                   r_rd_en;
    logic [11:0]            r_addr;
    logic [11:0]            r_base;
    logic                   r_oob;
    logic [1:0]             r_cnt;
    logic [FRAC_BITS-1:0]   r_fx;
    logic [FRAC_BITS-1:0]   r_fy;
    logic [WORD_SIZE-1:0]   r_w00;
    logic [WORD_SIZE-1:0]   r_w10;
    logic [WORD_SIZE-1:0]   r_w01;
    logic [WORD_SIZE-1:0]   r_w11;
    logic                   r_out_valid;
    logic                   r_out_oob;
    logic [31:0]            r_value;
    logic [31:0]            r_grad_x;
    logic [31:0]            r_grad_y;

    // integer part of the request coordinates, two's complement
    logic signed [13:0]     w_x0;
    logic signed [13:0]     w_y0;
    logic                   w_in_bounds;
    logic [11:0]            w_base;
    logic                   w_accept;
    logic                   w_capture;

    assign w_x0        = $signed(bus.in_x[31:FRAC_BITS]);
    assign w_y0        = $signed(bus.in_y[31:FRAC_BITS]);
    assign w_in_bounds = (w_x0 >= 14'sd0) && (w_x0 <= X_MAX) &&
                         (w_y0 >= 14'sd0) && (w_y0 <= Y_MAX);
    assign w_base      = 12'(int'(w_y0) * MAP_WIDTH + int'(w_x0));
    assign w_accept    = (r_state == S_IDLE) && r_in_ready && bus.in_valid;

    // the RAM word for a read issued in one FETCH cycle is present one cycle later,
    // so captures run from the second FETCH cycle through DRAIN
    assign w_capture   = ((r_state == S_FETCH) && (r_cnt != 2'd0)) || (r_state == S_DRAIN);

    // interpolation arithmetic: weights are F - f, exact products, no intermediate rounding
    logic [FRAC_BITS:0]     w_fxc;
    logic [FRAC_BITS:0]     w_fyc;
    logic [45:0]            w_row_a;
    logic [45:0]            w_row_b;
    logic [45:0]            w_blend;
    logic signed [31:0]     w_gx_sum;
    logic signed [31:0]     w_gy_sum;

    assign w_fxc   = 19'(1 << FRAC_BITS) - {1'b0, r_fx};
    assign w_fyc   = 19'(1 << FRAC_BITS) - {1'b0, r_fy};
    assign w_row_a = 46'(r_fx) * 46'(r_w10) + 46'(w_fxc) * 46'(r_w00);
    assign w_row_b = 46'(r_fx) * 46'(r_w11) + 46'(w_fxc) * 46'(r_w01);
    assign w_blend = 46'(r_fy) * w_row_b + 46'(w_fyc) * w_row_a;

    assign w_gx_sum = $signed(32'(r_fy))  * ($signed(32'(r_w11)) - $signed(32'(r_w01))) +
                      $signed(32'(w_fyc)) * ($signed(32'(r_w10)) - $signed(32'(r_w00)));
    assign w_gy_sum = $signed(32'(r_fx))  * ($signed(32'(r_w11)) - $signed(32'(r_w10))) +
                      $signed(32'(w_fxc)) * ($signed(32'(r_w01)) - $signed(32'(r_w00)));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state; the OOB path spends two cycles in CALC so its latency matches the bounds stage
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_in_bounds ? S_FETCH : S_CALC;
                end
            end
            S_FETCH: begin
                if (r_cnt == 2'd3) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_CALC;
            end
            S_CALC: begin
                if (!(r_oob && (r_cnt == 2'd0))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // request capture, sequencing counter and registered RAM read strobe/address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_base     <= '0;
            r_oob      <= 1'b0;
            r_cnt      <= '0;
            r_fx       <= '0;
            r_fy       <= '0;
        end else begin
            r_in_ready <= (w_next == S_IDLE);
            r_rd_en    <= (w_next == S_FETCH);
            if (w_accept) begin
                r_oob  <= !w_in_bounds;
                r_base <= w_base;
                r_fx   <= bus.in_x[FRAC_BITS-1:0];
                r_fy   <= bus.in_y[FRAC_BITS-1:0];
                r_cnt  <= '0;
                if (w_in_bounds) begin
                    r_addr <= w_base;
                end
            end else if ((r_state == S_FETCH) || (r_state == S_CALC)) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if ((r_state == S_FETCH) && (w_next == S_FETCH)) begin
                case (r_cnt)
                    2'd0:    r_addr <= r_base + 12'd1;
                    2'd1:    r_addr <= r_base + 12'(MAP_WIDTH);
                    default: r_addr <= r_base + 12'(MAP_WIDTH + 1);
                endcase
            end
        end
    end

    // neighbour words arrive in order w00, w10, w01, w11 and shift down into place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w00 <= '0;
            r_w10 <= '0;
            r_w01 <= '0;
            r_w11 <= '0;
        end else if (w_capture) begin
            r_w00 <= r_w10;
            r_w10 <= r_w01;
            r_w01 <= r_w11;
            r_w11 <= bus.ram_read_data;
        end
    end

    // result registers: loaded once on entry to DONE and held until the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_oob   <= 1'b0;
            r_value     <= '0;
            r_grad_x    <= '0;
            r_grad_y    <= '0;
        end else if ((r_state == S_CALC) && (w_next == S_DONE)) begin
            r_out_valid <= 1'b1;
            r_out_oob   <= r_oob;
            r_value     <= r_oob ? 32'd0 : 32'(w_blend >> 26);
            r_grad_x    <= r_oob ? 32'd0 : 32'(w_gx_sum >>> 8);
            r_grad_y    <= r_oob ? 32'd0 : 32'(w_gy_sum >>> 8);
        end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready        = r_in_ready;
    assign bus.ram_address     = r_addr;
    assign bus.ram_read_enable = r_rd_en;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_value       = r_value;
    assign bus.out_gradient_x  = r_grad_x;
    assign bus.out_gradient_y  = r_grad_y;
    assign bus.out_of_bounds   = r_out_oob;
endmodule

// File: tb/tb_map_bilinear_sampler.sv
// tb/tb_map_bilinear_sampler.sv - self-checking bench for map_bilinear_sampler
module tb_map_bilinear_sampler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    map_bilinear_sampler_if bus ();

    map_bilinear_sampler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit blocked = 1'b1;
    int acc_edge = 0;

    logic [7:0] mem [0:4095];

    // synchronous map RAM: word appears one cycle after the enable cycle
    always @(posedge clk) begin
        if (bus.ram_read_enable) bus.ram_read_data <= mem[bus.ram_address];
    end

    // edge counter and "reset seen at this edge" flag for the in_ready expectation
    always @(posedge clk) begin
        cyc++;
        blocked = !rst_n;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference: bilinear sample of the map straight from the arithmetic definition
    task automatic model(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] v, output logic [31:0] gx, output logic [31:0] gy,
                         output bit oob, output int base);
        int x0, y0;
        longint fx, fy, ff, w00, w10, w01, w11, a, b, sx, sy;
        x0 = $signed(x) >>> 18;
        y0 = $signed(y) >>> 18;
        fx = longint'(x[17:0]);
        fy = longint'(y[17:0]);
        ff = 64'd262144;
        oob = !(x0 >= 0 && x0 <= 126 && y0 >= 0 && y0 <= 30);
        base = 0;
        v = 0; gx = 0; gy = 0;
        if (!oob) begin
            base = y0 * 128 + x0;
            w00 = longint'(mem[base]);
            w10 = longint'(mem[base + 1]);
            w01 = longint'(mem[base + 128]);
            w11 = longint'(mem[base + 129]);
            a  = fx * w10 + (ff - fx) * w00;
            b  = fx * w11 + (ff - fx) * w01;
            v  = 32'((fy * b + (ff - fy) * a) >> 26);
            sx = fy * (w11 - w01) + (ff - fy) * (w10 - w00);
            sy = fx * (w11 - w10) + (ff - fx) * (w01 - w00);
            gx = 32'(sx >>> 8);
            gy = 32'(sy >>> 8);
        end
    endtask

    // model state for the one transaction that may be in flight
    bit          have_txn = 1'b0;
    int          k_edge = 0;
    int          rise_edge = 0;
    int          m_base = 0;
    bit          m_oob = 1'b0;
    logic [31:0] m_v, m_gx, m_gy;

    // per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        bit exp_rd, exp_ov;
        int off;
        if (!rst_n) have_txn = 1'b0;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rst_n && !blocked && !have_txn});
        exp_rd = have_txn && !m_oob && (cyc >= k_edge) && (cyc <= k_edge + 3);
        chk("ram_read_enable", {31'd0, bus.ram_read_enable}, {31'd0, exp_rd});
        if (exp_rd) begin
            off = (cyc == k_edge) ? 0 : (cyc == k_edge + 1) ? 1 : (cyc == k_edge + 2) ? 128 : 129;
            chk("ram_address", {20'd0, bus.ram_address}, 32'(m_base + off));
        end
        exp_ov = have_txn && (cyc >= rise_edge);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_value", bus.out_value, m_v);
            chk("out_gradient_x", bus.out_gradient_x, m_gx);
            chk("out_gradient_y", bus.out_gradient_y, m_gy);
            chk("out_of_bounds", {31'd0, bus.out_of_bounds}, {31'd0, m_oob});
            if (bus.out_ready) have_txn = 1'b0;
        end
        if (rst_n && bus.in_valid && bus.in_ready) begin
            model(bus.in_x, bus.in_y, m_v, m_gx, m_gy, m_oob, m_base);
            have_txn  = 1'b1;
            k_edge    = cyc + 1;
            rise_edge = k_edge + (m_oob ? 2 : 6);
        end
    end

    // present a point; returns at acceptance edge + 1 time unit
    task automatic send(input logic [31:0] x, input logic [31:0] y, input bit keep_valid);
        bit ok = 1'b0;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                acc_edge = cyc;
                ok = 1'b1;
            end
        end
        if (!keep_valid) bus.in_valid = 1'b0;
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    // wait for the result, check latency and (optionally) hand-computed values, then take the handshake edge
    task automatic wait_result(input string nm, input bit lit, input logic [31:0] ev,
                               input logic [31:0] egx, input logic [31:0] egy,
                               input bit eoob, input int elat);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({nm, "_latency"}, 32'(cyc - acc_edge), 32'(elat));
            if (lit) begin
                chk({nm, "_value"}, bus.out_value, ev);
                chk({nm, "_grad_x"}, bus.out_gradient_x, egx);
                chk({nm, "_grad_y"}, bus.out_gradient_y, egy);
                chk({nm, "_oob"}, {31'd0, bus.out_of_bounds}, {31'd0, eoob});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, nvalid;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, bus.ram_read_enable}, 32'd0);
        chk("rst_value", bus.out_value, 32'd0);
        chk("rst_address", {20'd0, bus.ram_address}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // interpolation at (3.5, 2.25)
        mem[259] = 8'd0; mem[260] = 8'd128; mem[387] = 8'd64; mem[388] = 8'd192;
        send(32'h000E0000, 32'h00090000, 1'b0);
        chk("interp_addr0", {20'd0, bus.ram_address}, 32'd259);
        @(posedge clk); #1;
        chk("interp_addr1", {20'd0, bus.ram_address}, 32'd260);
        @(posedge clk); #1;
        chk("interp_addr2", {20'd0, bus.ram_address}, 32'd387);
        @(posedge clk); #1;
        chk("interp_addr3", {20'd0, bus.ram_address}, 32'd388);
        chk("interp_en3", {31'd0, bus.ram_read_enable}, 32'd1);
        wait_result("interp", 1'b1, 32'h00014000, 32'h00020000, 32'h00010000, 1'b0, 6);

        // integer point (5.0, 1.0)
        mem[133] = 8'd200; mem[134] = 8'd0; mem[261] = 8'd0; mem[262] = 8'd0;
        send(32'h00140000, 32'h00040000, 1'b0);
        wait_result("integer", 1'b1, 32'h00032000, 32'hFFFCE000, 32'hFFFCE000, 1'b0, 6);

        // negative gradient at (10.0, 10.0)
        mem[1290] = 8'd255; mem[1291] = 8'd0; mem[1418] = 8'd0; mem[1419] = 8'd0;
        send(32'h00280000, 32'h00280000, 1'b0);
        wait_result("neggrad", 1'b1, 32'h0003FC00, 32'hFFFC0400, 32'hFFFC0400, 1'b0, 6);

        // out-of-bounds points
        send(32'h01FC0000, 32'h00090000, 1'b0);
        wait_result("oob_x127", 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        send(32'h000E0000, 32'hFFFE0000, 1'b0);
        wait_result("oob_yneg", 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        send(32'h000E0000, 32'h007C0000, 1'b0);
        wait_result("oob_y31", 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        send(32'hFFFC0000, 32'h00040000, 1'b0);
        wait_result("oob_xneg", 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 2);

        // in-bounds corners, checked against the model only
        send(32'h01FBFFFF, 32'h007BFFFF, 1'b0);
        wait_result("corner_max", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 6);
        send(32'h00001234, 32'h0003FFFF, 1'b0);
        wait_result("corner_min", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 6);
        send(32'h00A2A5A5, 32'h00315A5A, 1'b0);
        wait_result("mid", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 6);

        // backpressure with a second point waiting
        bus.out_ready = 1'b0;
        send(32'h000E0000, 32'h00090000, 1'b1);
        bus.in_x = 32'h00140000;
        bus.in_y = 32'h00040000;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            chk("bp_seen", {31'd0, seen}, 32'd1);
            chk("bp_latency", 32'(cyc - acc_edge), 32'd6);
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_value", bus.out_value, 32'h00014000);
            chk("bp_grad_x", bus.out_gradient_x, 32'h00020000);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        h = cyc;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    @(posedge clk); #1;
                    acc_edge = cyc;
                    ok = 1'b1;
                end
            end
            chk("bp_second_accept", {31'd0, ok}, 32'd1);
        end
        bus.in_valid = 1'b0;
        chk("bp_accept_edge", 32'(acc_edge - h), 32'd1);
        wait_result("bp_second", 1'b1, 32'h00032000, 32'hFFFCE000, 32'hFFFCE000, 1'b0, 6);

        // reset during the second FETCH cycle
        send(32'h000E0000, 32'h00090000, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", {31'd0, bus.ram_read_enable}, 32'd0);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_ready", {31'd0, bus.in_ready}, 32'd1);
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
        end
        chk("midrst_no_output", 32'(nvalid), 32'd0);

        // normal operation resumes after the mid-transaction reset
        @(posedge clk); #1;
        send(32'h000E0000, 32'h00090000, 1'b0);
        wait_result("after_rst", 1'b1, 32'h00014000, 32'h00020000, 32'h00010000, 1'b0, 6);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/map_bilinear_sampler.md
Name: map_bilinear_sampler

Overview:
- Consumes occupancy-grid map memory (128x32 cells, 8-bit words, 12-bit address) for the scan matcher.
- Accepts one map-coordinate point (Q14.18 `fixed_t`) per transaction and reads the four surrounding cells over a synchronous RAM read port.
- Returns the bilinearly interpolated occupancy value and its x/y gradients, all as `fixed_t`.
- Sits between the map RAM and the Gauss-Newton accumulation stage.

Parameters:
- MAP_WIDTH, 128 (`ram_pkg::WIDTH`), cells per map row.
- MAP_HEIGHT, 32 (`ram_pkg::HEIGHT`), map rows.
- WORD_SIZE, 8 (`ram_pkg::WORD_SIZE`), bits per cell; cell word w represents occupancy w/256.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Point request valid.
- in_ready  out  1  Ready to accept a point.
- in_x  in  32  Map x coordinate, `fixed_t`; `integer_` field is two's complement.
- in_y  in  32  Map y coordinate, `fixed_t`; `integer_` field is two's complement.
- ram_address  out  12  Read address, y*MAP_WIDTH + x; registered.
- ram_read_enable  out  1  Read strobe; registered.
- ram_read_data  in  8  Word returned exactly 1 cycle after the enable cycle.
- out_valid  out  1  Result valid.
- out_ready  in  1  Downstream accepts result.
- out_value  out  32  Interpolated occupancy, `fixed_t`.
- out_gradient_x  out  32  dM/dx, `fixed_t`, two's complement.
- out_gradient_y  out  32  dM/dy, `fixed_t`, two's complement.
- out_of_bounds  out  1  Point outside the interpolable area; results are zero.

Behaviour:
- **Reset** (asynchronous, any state): FSM to IDLE. in_ready=0 during reset, 1 in the first cycle after release. All other outputs 0.
- **FSM states**: IDLE → FETCH (4 cycles) → DRAIN → CALC → DONE → IDLE. OOB path: IDLE → CALC → DONE.
- **Acceptance**:
  - in_ready=1 only in IDLE; a transfer occurs on an edge where in_valid && in_ready.
  - On acceptance, register x0 = in_x.integer_, y0 = in_y.integer_, fx = in_x.fraction, fy = in_y.fraction.
- **Bounds check**: in bounds iff 0 ≤ x0 ≤ MAP_WIDTH-2 and 0 ≤ y0 ≤ MAP_HEIGHT-2. Otherwise take the OOB path: no RAM reads, all results 0, out_of_bounds=1.
- **FETCH** (acceptance at edge k):
  - ram_read_enable=1 for the 4 cycles following edge k.
  - Addresses in order: A00 = y0*W + x0, A10 = A00+1, A01 = A00+W, A11 = A00+W+1.
  - Words w00, w10, w01, w11 are captured at edges k+2 through k+5.
  - ram_read_enable=0 at all other times; ram_address holds its last value.
- **CALC** (exact unsigned/signed integer math, no intermediate rounding; F = 2^18):
  - A = fx*w10 + (F-fx)*w00
  - B = fx*w11 + (F-fx)*w01
  - out_value = (fy*B + (F-fy)*A) >> 26, floor.
  - out_gradient_x = (fy*(w11-w01) + (F-fy)*(w10-w00)) >>> 8, arithmetic.
  - out_gradient_y = (fx*(w11-w10) + (F-fx)*(w01-w00)) >>> 8, arithmetic.
- **Latency**:
  - In bounds: out_valid rises at edge k+6.
  - OOB: out_valid rises at edge k+2.
- **DONE**:
  - out_valid=1 and all result outputs held stable until out_valid && out_ready.
  - On that edge out_valid→0 and the FSM returns to IDLE; in_ready rises the same edge, so at most one transaction is in flight.
  - in_valid is ignored outside IDLE.
- **Invariants**:
  - Results and out_of_bounds never change while out_valid=1.
  - ram_read_enable is never high outside FETCH.
  - Reset mid-FETCH drops the transaction with no output.

Test Plan:
- **Interpolation**: in_x=3.5, in_y=2.25; RAM w00=0, w10=128, w01=64, w11=192 → addresses 259, 260, 387, 388 on 4 consecutive cycles; out_value=0x00014000, grad_x=0x00020000, grad_y=0x00010000, out_of_bounds=0; out_valid at acceptance+6.
- **Integer point**: in_x=5.0, in_y=1.0, w00=200, others 0 → out_value=0x00032000, grad_x=0xFFFCE000, grad_y=0xFFFCE000.
- **Negative gradient**: fx=fy=0, w00=255, others 0 → grad_x=grad_y=0xFFFC0400.
- **OOB cases**: in_x=127.0, in_y=-0.5, and in_y=31.0 each → ram_read_enable never asserted; out_of_bounds=1, all results 0; out_valid at acceptance+2.
- **Backpressure**: out_ready=0 for 10 cycles after out_valid, in_valid=1 throughout → outputs stable, in_ready=0, no new acceptance; second point accepted the edge after the out handshake.
- **Reset mid-operation**: rst_n low during the 2nd FETCH cycle → ram_read_enable=0 and out_valid=0 immediately; in_ready=1 the cycle after release; no result emitted.
